// File: rtl/muldiv_unit.sv
// Iterative MIPS32 multiply/divide unit writing architectural HI/LO, plus MTHI/MTLO.
// Latency: start sampled at edge k -> hi/lo written and done=1 from edge k+XLEN+1.
// Backpressure: none accepted; stall_req holds IF/ID while an MFHI/MFLO waits on busy or start.
//
// Ports:
//   clk, rst (async active-low)
//   start/op/a/b  : launch MULT(00) MULTU(01) DIV(10) DIVU(11)
//   flush         : kill in-flight op
//   wr_hi/wr_lo/wr_data : MTHI/MTLO writes (abort any in-flight op)
//   rd_hilo       : ID stage holds MFHI/MFLO
//   busy/done/dbz/stall_req, hi/lo : status and architectural registers
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [XLEN-1:0] wr_data,
  input  logic            rd_hilo,
  output logic            busy,
  output logic            done,
  output logic            dbz,
  output logic            stall_req,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  acc_hi;   // mul: upper partial product; div: remainder
  logic [XLEN-1:0]  acc_lo;   // mul: multiplier/low product; div: dividend/quotient
  logic [XLEN-1:0]  mag_b;
  logic [XLEN-1:0]  a_raw;    // kept for the divide-by-zero hi result
  logic             is_div;
  logic             b_zero;
  logic             neg_p;    // product (mul) / quotient (div) is negative
  logic             neg_r;    // remainder is negative (dividend sign)

  // Operand capture: signed ops work on magnitudes, signs reapplied in FIX.
  logic            sgn_op;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] mag_a_in;
  logic [XLEN-1:0] mag_b_in;

  always_comb begin
    sgn_op   = ~op[0];
    sa       = sgn_op & a[XLEN-1];
    sb       = sgn_op & b[XLEN-1];
    mag_a_in = sa ? (~a + 1'b1) : a;
    mag_b_in = sb ? (~b + 1'b1) : b;
  end

  // One shift-add multiply step: add multiplicand if LSB set, then shift the
  // {acc_hi, acc_lo} pair right so the product assembles in place.
  logic [XLEN:0] mul_sum;
  // One restoring divide step: shift dividend bit into remainder, try subtract.
  // Since remainder < divisor, the shifted value fits XLEN+1 bits and the
  // top bit of the difference is a clean borrow flag.
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : {(XLEN+1){1'b0}});
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag_b};
  end

  // Sign correction / special cases applied on the FIX exit edge.
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   fix_hi;
  logic [XLEN-1:0]   fix_lo;

  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_p ? (~prod + 1'b1) : prod;
    fix_hi   = prod_fix[2*XLEN-1:XLEN];
    fix_lo   = prod_fix[XLEN-1:0];
    if (is_div) begin
      if (b_zero) begin
        fix_lo = '1;
        fix_hi = a_raw;
      end else begin
        // Most-negative / -1 falls out naturally: magnitude quotient 2**(XLEN-1)
        // negates to itself, remainder 0.
        fix_lo = neg_p ? (~acc_lo + 1'b1) : acc_lo;
        fix_hi = neg_r ? (~acc_hi + 1'b1) : acc_hi;
      end
    end
  end

  assign stall_req = rd_hilo & (busy | start);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mag_b  <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      b_zero <= 1'b0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dbz    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      dbz  <= 1'b0;
      if (flush) begin
        // Kill anything in flight; a coincident start is dropped.
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        if (wr_hi) hi <= wr_data;
        if (wr_lo) lo <= wr_data;
        if (start) begin
          state  <= RUN;
          busy   <= 1'b1;
          cnt    <= CNT_W'(XLEN-1);
          acc_hi <= '0;
          acc_lo <= mag_a_in;
          mag_b  <= mag_b_in;
          a_raw  <= a;
          is_div <= op[1];
          b_zero <= (b == '0);
          neg_p  <= sa ^ sb;
          neg_r  <= sa;
        end else if (wr_hi || wr_lo) begin
          // MTHI/MTLO overrides any pending result.
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          case (state)
            IDLE: ;
            RUN: begin
              if (is_div) begin
                if (!div_diff[XLEN]) begin
                  acc_hi <= div_diff[XLEN-1:0];
                  acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
                end else begin
                  acc_hi <= div_shift[XLEN-1:0];
                  acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
                end
              end else begin
                acc_hi <= mul_sum[XLEN:1];
                acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
              end
              cnt <= cnt - 1'b1;
              if (cnt == '0) state <= FIX;
            end
            FIX: begin
              hi    <= fix_hi;
              lo    <= fix_lo;
              done  <= 1'b1;
              dbz   <= is_div & b_zero;
              busy  <= 1'b0;
              state <= DONE;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            flush = 1'b0;
  logic            wr_hi = 1'b0;
  logic            wr_lo = 1'b0;
  logic [XLEN-1:0] wr_data = '0;
  logic            rd_hilo = 1'b0;
  logic            busy;
  logic            done;
  logic            dbz;
  logic            stall_req;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .rd_hilo(rd_hilo), .busy(busy), .done(done), .dbz(dbz),
    .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch op, then check the full latency profile and result.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz);
    @(negedge clk);
    op = o; a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    repeat (32) @(negedge clk);
    chk({tag, "_early"}, 64'(done), 64'd0);
    @(negedge clk);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_hi"}, 64'(hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo), 64'(elo));
    chk({tag, "_dbz"}, 64'(dbz), 64'(edbz));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int cnt_done;
    int stall_bad;

    // Reset state
    #12;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Arithmetic cases
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult_neg",  2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_op("div_neg",   2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_negb",  2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_op("divu",      2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
    run_op("divu_dbz",  2'b11, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF, 1'b1);
    run_op("div_dbz",   2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
    run_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);

    // Flush mid-op after MTHI/MTLO preload
    @(negedge clk);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h12345678;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    chk("mt_hi", 64'(hi), 64'h12345678);
    chk("mt_lo", 64'(lo), 64'h12345678);
    op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    cnt_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    chk("flush_nodone", 64'(cnt_done), 64'd0);
    chk("flush_hi", 64'(hi), 64'h12345678);
    chk("flush_lo", 64'(lo), 64'h12345678);

    // stall_req across an op, with restart mid-RUN
    stall_bad = 0;
    @(negedge clk);
    rd_hilo = 1'b1; op = 2'b00; a = 32'd7; b = 32'd6; start = 1'b1;
    #1;
    chk("stall_start", 64'(stall_req), 64'd1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (!stall_req) stall_bad++;
      @(negedge clk);
    end
    op = 2'b00; a = 32'hFFFFFFFE; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (!stall_req) stall_bad++;
      @(negedge clk);
    end
    if (!stall_req) stall_bad++;
    chk("stall_run", 64'(stall_bad), 64'd0);
    chk("restart_early", 64'(done), 64'd0);
    @(negedge clk);
    chk("restart_done", 64'(done), 64'd1);
    chk("restart_hi", 64'(hi), 64'hFFFFFFFF);
    chk("restart_lo", 64'(lo), 64'hFFFFFFFA);
    chk("stall_done", 64'(stall_req), 64'd0);
    rd_hilo = 1'b0;

    // Asynchronous reset mid-RUN
    @(negedge clk);
    op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    cnt_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    chk("arst_nodone", 64'(cnt_done), 64'd0);

    // MTLO together with start in IDLE
    @(negedge clk);
    wr_lo = 1'b1; wr_data = 32'hAAAA5555;
    op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
    @(negedge clk);
    wr_lo = 1'b0; start = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'hAAAA5555);
    chk("mtlo_busy", 64'(busy), 64'd1);
    repeat (32) @(negedge clk);
    @(negedge clk);
    chk("mtlo_done", 64'(done), 64'd1);
    chk("mtlo_res_lo", 64'(lo), 64'd6);
    chk("mtlo_res_hi", 64'(hi), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
